permute_host: RTL and testbench

Host-side responder for the permute core's control unit. It buffers one 64-word frame from an upstream valid/ready stream and pulses `start`. It then serves an input word on every `core_read` strobe and captures a result word on every `core_ready` strobe. Once all 64 results are captured, it drains them to a downstream valid/ready stream. It sits between the system datapath and the permute core and closes the core's read/ready protocol from the other end.

---
 rtl/permute_pkg.sv | 24 ++
 rtl/frame_buf.sv | 26 ++
 rtl/permute_host.sv | 182 ++++++++++++++++++
 tb/tb_permute_host.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/permute_pkg.sv
// Shared constants, state encoding and helpers for the permute host.
package permute_pkg;

    localparam int unsigned FRAME_LEN = 64;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned IDX_W     = 6;

    typedef enum logic [1:0] {
        StFill,
        StStart,
        StRun,
        StDrain
    } host_state_e;

    // True when the counter is about to take its last frame step.
    function automatic logic cnt_last(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(FRAME_LEN - 1);
    endfunction

    function automatic logic cnt_full(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(FRAME_LEN);
    endfunction

endpackage

// File: rtl/frame_buf.sv
// One-frame register array: a synchronous write port and a combinational read port.
module frame_buf
    import permute_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    // Contents are deliberately not reset.
    logic [W-1:0] mem_q [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/permute_host.sv
// Host-side responder for the permute core: fills a frame, starts the core, serves reads,
// captures results and drains them. Define PERMUTE_HOST_CHK_EN for the err_o protocol checker.
module permute_host
    import permute_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         start_o,
    output logic [W-1:0] core_din_o,
    input  logic         core_read_i,
    input  logic         core_ready_i,
    input  logic [W-1:0] core_dout_i,
    input  logic         core_total_ready_i,
    output logic         busy_o
`ifdef PERMUTE_HOST_CHK_EN
    ,
    output logic         err_o
`endif
);

    host_state_e state_q, state_d;

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0] drn_cnt_q, drn_cnt_d;

    logic             in_we;
    logic             out_we;
    logic [IDX_W-1:0] in_raddr;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        res_cnt_d   = res_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        start_o     = 1'b0;
        busy_o      = 1'b0;
        in_we       = 1'b0;
        out_we      = 1'b0;

        unique case (state_q)
            StFill: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    in_we    = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (cnt_last(wr_cnt_q)) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                busy_o = 1'b1;
                if (core_total_ready_i) begin
                    start_o   = 1'b1;
                    rd_cnt_d  = '0;
                    res_cnt_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                busy_o = 1'b1;
                // Reads past the frame end are not counted so the index never wraps silently.
                if (core_read_i && !cnt_full(rd_cnt_q)) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (core_ready_i) begin
                    out_we    = 1'b1;
                    res_cnt_d = res_cnt_q + CNT_W'(1);
                    if (cnt_last(res_cnt_q)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    drn_cnt_d = drn_cnt_q + CNT_W'(1);
                    if (cnt_last(drn_cnt_q)) begin
                        wr_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        res_cnt_d = '0;
                        drn_cnt_d = '0;
                        state_d   = StFill;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFill;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            res_cnt_q <= '0;
            drn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            res_cnt_q <= res_cnt_d;
            drn_cnt_q <= drn_cnt_d;
        end
    end

    // Outside RUN the core sees word 0 of the frame.
    assign in_raddr = (state_q == StRun) ? rd_cnt_q[IDX_W-1:0] : '0;

    frame_buf #(
        .W (W)
    ) u_inbuf (
        .clk     (clk),
        .we_i    (in_we),
        .waddr_i (wr_cnt_q[IDX_W-1:0]),
        .wdata_i (in_data_i),
        .raddr_i (in_raddr),
        .rdata_o (core_din_o)
    );

    frame_buf #(
        .W (W)
    ) u_outbuf (
        .clk     (clk),
        .we_i    (out_we),
        .waddr_i (res_cnt_q[IDX_W-1:0]),
        .wdata_i (core_dout_i),
        .raddr_i (drn_cnt_q[IDX_W-1:0]),
        .rdata_o (out_data_o)
    );

`ifdef PERMUTE_HOST_CHK_EN
    logic err_q, err_d;
    logic first_run_q;

    always_comb begin
        err_d = err_q;
        if (state_q == StRun) begin
            if (core_read_i && cnt_full(rd_cnt_q)) begin
                err_d = 1'b1;
            end
            if (core_ready_i && (res_cnt_q >= rd_cnt_q)) begin
                err_d = 1'b1;
            end
            // The core may still report idle in the cycle right after start.
            if (core_total_ready_i && !first_run_q) begin
                err_d = 1'b1;
            end
        end else if (core_read_i || core_ready_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q       <= 1'b0;
            first_run_q <= 1'b0;
        end else begin
            err_q       <= err_d;
            first_run_q <= start_o;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_permute_host.sv
// Randomized scoreboard bench for permute_host with a behavioural permute-core model.
module tb_permute_host;

    localparam int          W    = 32;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         start;
    logic [W-1:0] core_din;
    logic         core_read;
    logic         core_ready;
    logic [W-1:0] core_dout;
    logic         core_total_ready;
    logic         busy;
`ifdef PERMUTE_HOST_CHK_EN
    logic         err;
`endif

    permute_host #(
        .W (W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_data_i          (in_data),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_data_o         (out_data),
        .start_o            (start),
        .core_din_o         (core_din),
        .core_read_i        (core_read),
        .core_ready_i       (core_ready),
        .core_dout_i        (core_dout),
        .core_total_ready_i (core_total_ready),
        .busy_o             (busy)
`ifdef PERMUTE_HOST_CHK_EN
        ,
        .err_o              (err)
`endif
    );

    always #5 clk = ~clk;

    int           n_cmp     = 0;
    int           n_fail    = 0;
    int           start_cnt = 0;
    logic [W-1:0] frame [64];
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected word per downstream transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (start) start_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_extra: got %h want no transfer", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            if (busy || out_valid) check("in_ready_outside_fill", 32'(in_ready), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Tasks start and end at one time unit after a rising edge.
    task automatic fill(input bit rnd);
        int i     = 0;
        int guard = 0;
        while (i < 64 && guard < 2000) begin
            in_valid = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            in_data  = frame[i[5:0]];
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(frame[i[5:0]] ^ MASK);
                i++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (i < 64) check("fill_timeout", 32'(i), 32'd64);
    endtask

    task automatic drain(input bit rnd);
        int  guard = 0;
        bit  done  = 0;
        while (!done && guard < 2000) begin
            out_ready = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        if (!done) check("drain_timeout", 32'(guard), 32'd0);
    endtask

    // Permute-core model: k-th read receives frame word k; each result is that word ^ MASK.
    task automatic run_core(input bit fixed, input int abort_at, input bit extra,
                            output int waited, output bit aborted);
        int           reads   = 0;
        int           results = 0;
        int           n       = 0;
        int           prev;
        bit           got     = 0;
        bit           rd;
        bit           rdy;
        logic [W-1:0] din_q [$];
        aborted = 0;
        waited  = 0;
        while (!got && waited < 100) begin
            @(negedge clk);
            if (start) got = 1;
            @(posedge clk);
            #1;
            if (!got) waited++;
        end
        if (!got) begin
            check("start_timeout", 32'(waited), 32'd0);
            aborted = 1;
            return;
        end
        core_total_ready = 1'b0;
        n = 1;
        while (results < 64 && n < 1000) begin
            prev = reads;
            if (fixed) begin
                rd  = (n >= 2) && ((n - 2) % 3 == 0) && (reads < 64);
                rdy = (n >= 4) && ((n - 4) % 3 == 0) && (results < prev);
            end else begin
                rd  = (reads < 64) && ($urandom_range(1, 0) == 1);
                rdy = (results < prev) && ($urandom_range(1, 0) == 1);
            end
            core_read  = rd || (fixed && extra && n == 192);
            core_ready = rdy;
            core_dout  = rdy ? (din_q[results] ^ MASK) : $urandom;
            @(negedge clk);
            if (rd) begin
                check("core_din", core_din, frame[reads[5:0]]);
                din_q.push_back(core_din);
                reads++;
            end
            if (rdy) results++;
            @(posedge clk);
            #1;
            n++;
            if (abort_at >= 0 && results == abort_at) begin
                core_read  = 1'b0;
                core_ready = 1'b0;
                rst        = 1'b1;
                #1;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_wr_cnt", 32'(dut.wr_cnt_q), 32'd0);
                check("rst_rd_cnt", 32'(dut.rd_cnt_q), 32'd0);
                check("rst_res_cnt", 32'(dut.res_cnt_q), 32'd0);
                check("rst_drn_cnt", 32'(dut.drn_cnt_q), 32'd0);
                exp_q.delete();
                core_total_ready = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_in_ready", 32'(in_ready), 32'd1);
                @(posedge clk);
                #1;
                aborted = 1;
                return;
            end
        end
        core_read        = 1'b0;
        core_ready       = 1'b0;
        core_total_ready = 1'b1;
        if (results < 64) begin
            check("run_timeout", 32'(results), 32'd64);
            aborted = 1;
            return;
        end
        if (fixed) begin
            check("drain_entry_cycle", 32'(n), 32'd194);
            check("drain_entry_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic do_frame(input bit fixed, input bit rnd_in, input bit rnd_out,
                            input int gate, input int abort_at, input bit extra);
        int waited;
        bit aborted;
        start_cnt        = 0;
        core_total_ready = (gate == 0);
        fill(rnd_in);
        for (int c = 0; c < gate; c++) begin
            @(negedge clk);
            check("gate_start_low", 32'(start), 32'd0);
            check("gate_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        core_total_ready = 1'b1;
        run_core(fixed, abort_at, extra, waited, aborted);
        if (aborted) return;
        check("start_latency", 32'(waited), 32'd0);
        @(negedge clk);
        check("core_din_idle", core_din, frame[0]);
        @(posedge clk);
        #1;
        drain(rnd_out);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("start_count", 32'(start_cnt), 32'd1);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 64; i++) frame[i[5:0]] = $urandom;
    endtask

    initial begin
        in_valid         = 1'b0;
        in_data          = '0;
        out_ready        = 1'b0;
        core_read        = 1'b0;
        core_ready       = 1'b0;
        core_dout        = '0;
        core_total_ready = 1'b1;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_start", 32'(start), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_cnt", 32'(dut.wr_cnt_q), 32'd0);
`ifdef PERMUTE_HOST_CHK_EN
        check("reset_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Identity frame with the nominal core timing.
        for (int i = 0; i < 64; i++) frame[i[5:0]] = 32'(i);
        do_frame(1'b1, 1'b0, 1'b0, 0, -1, 1'b0);
`ifdef PERMUTE_HOST_CHK_EN
        check("err_clean", 32'(err), 32'd0);
`endif

        // Start gated by a busy core for 10 cycles.
        rand_frame();
        do_frame(1'b0, 1'b0, 1'b0, 10, -1, 1'b0);

        // Backpressure on both streams with random core strobes.
        rand_frame();
        do_frame(1'b0, 1'b1, 1'b1, 0, -1, 1'b0);
        rand_frame();
        do_frame(1'b0, 1'b1, 1'b1, 0, -1, 1'b0);

        // Reset at result 30, then a fresh frame.
        rand_frame();
        do_frame(1'b0, 1'b0, 1'b0, 0, 30, 1'b0);
        rand_frame();
        do_frame(1'b0, 1'b1, 1'b1, 0, -1, 1'b0);
`ifdef PERMUTE_HOST_CHK_EN
        check("err_clean_random", 32'(err), 32'd0);
`endif

        // Extra read after the 64th read.
        rand_frame();
        do_frame(1'b1, 1'b0, 1'b0, 0, -1, 1'b1);
`ifdef PERMUTE_HOST_CHK_EN
        check("err_set", 32'(err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        #1;
        check("err_cleared", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
